// File: rtl/mfp_ahb_uart_pkg.sv
// rtl/mfp_ahb_uart_pkg.sv - register offsets, STATUS bit indices and FSM states for mfp_ahb_uart
package mfp_ahb_uart_pkg;

  localparam logic [1:0] UART_REG_TXDATA = 2'd0;
  localparam logic [1:0] UART_REG_RXDATA = 2'd1;
  localparam logic [1:0] UART_REG_STATUS = 2'd2;
  localparam logic [1:0] UART_REG_CTRL   = 2'd3;

  localparam int UART_ST_TX_FULL  = 0;
  localparam int UART_ST_TX_IDLE  = 1;
  localparam int UART_ST_RX_AVAIL = 2;
  localparam int UART_ST_RX_FULL  = 3;
  localparam int UART_ST_RXOVR    = 4;
  localparam int UART_ST_FRERR    = 5;
  localparam int UART_ST_TXOVF    = 6;

  localparam logic [15:0] MFP_UART_DEFAULT_DIV = 16'd433;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mfp_uart_fifo.sv
// rtl/mfp_uart_fifo.sv - synchronous first-word-fall-through FIFO used for the UART TX and RX queues
module mfp_uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [0:(2**AW)-1];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mfp_ahb_uart.sv
// rtl/mfp_ahb_uart.sv - AHB-lite 8N1 UART with TX/RX FIFOs and programmable baud divider
// Optional internal loopback on CTRL[16] when MFP_UART_LOOPBACK_EN is defined.
module mfp_ahb_uart
  import mfp_ahb_uart_pkg::*;
#(
  parameter int          FIFO_AW     = 4,
  parameter logic [15:0] DEFAULT_DIV = MFP_UART_DEFAULT_DIV
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        UART_TX,
  input  logic        UART_RX
);

  logic        r_sel_d, r_wr_d;
  logic [1:0]  r_addr_d;
  logic [15:0] r_baud_div;
  logic        r_rxovr, r_frerr, r_txovf;
  logic        w_loopback, w_unused;
  logic        w_wr, w_rd;
  logic [6:0]  w_status;

  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_line, w_txovf;
  logic [7:0]  w_tx_dout;
  uart_state_t r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bit;

  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ferr, w_rx_ovr;
  logic        w_rx_in, w_rx_fall;
  logic [7:0]  w_rx_dout;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  uart_state_t r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt, w_rx_half;
  logic [7:0]  r_rx_shift;
  logic [2:0]  r_rx_bit;

  assign w_wr = r_sel_d && r_wr_d;
  assign w_rd = r_sel_d && !r_wr_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sel_d  <= 1'b0;
      r_wr_d   <= 1'b0;
      r_addr_d <= 2'd0;
    end else begin
      r_sel_d  <= HSEL && HTRANS[1];
      r_wr_d   <= HWRITE;
      r_addr_d <= HADDR;
    end
  end

`ifdef MFP_UART_LOOPBACK_EN
  logic r_loopback;
  always_ff @(posedge HCLK) begin
    if (HRESET)                                r_loopback <= 1'b0;
    else if (w_wr && r_addr_d == UART_REG_CTRL) r_loopback <= HWDATA[16];
  end
  assign w_loopback = r_loopback;
  assign w_unused   = &{1'b0, HTRANS[0], HWDATA[31:17]};
`else
  assign w_loopback = 1'b0;
  assign w_unused   = &{1'b0, HTRANS[0], HWDATA[31:16]};
`endif

  assign w_tx_push = w_wr && (r_addr_d == UART_REG_TXDATA);
  assign w_rx_pop  = w_rd && (r_addr_d == UART_REG_RXDATA) && !w_rx_empty;
  assign w_txovf   = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_ovr  = w_rx_push && w_rx_full && !w_rx_pop;

  // Sticky error bits: a new event in the same cycle as a W1C clear wins.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_baud_div <= DEFAULT_DIV;
      r_rxovr    <= 1'b0;
      r_frerr    <= 1'b0;
      r_txovf    <= 1'b0;
    end else begin
      if (w_wr && r_addr_d == UART_REG_CTRL) r_baud_div <= HWDATA[15:0];
      if (w_wr && r_addr_d == UART_REG_STATUS) begin
        r_rxovr <= (r_rxovr && !HWDATA[UART_ST_RXOVR]) || w_rx_ovr;
        r_frerr <= (r_frerr && !HWDATA[UART_ST_FRERR]) || w_rx_ferr;
        r_txovf <= (r_txovf && !HWDATA[UART_ST_TXOVF]) || w_txovf;
      end else begin
        r_rxovr <= r_rxovr || w_rx_ovr;
        r_frerr <= r_frerr || w_rx_ferr;
        r_txovf <= r_txovf || w_txovf;
      end
    end
  end

  always_comb begin
    w_status                   = '0;
    w_status[UART_ST_TX_FULL]  = w_tx_full;
    w_status[UART_ST_TX_IDLE]  = w_tx_empty && (r_tx_state == UART_IDLE);
    w_status[UART_ST_RX_AVAIL] = !w_rx_empty;
    w_status[UART_ST_RX_FULL]  = w_rx_full;
    w_status[UART_ST_RXOVR]    = r_rxovr;
    w_status[UART_ST_FRERR]    = r_frerr;
    w_status[UART_ST_TXOVF]    = r_txovf;
  end

  always_comb begin
    HRDATA = '0;
    if (w_rd) begin
      case (r_addr_d)
        UART_REG_RXDATA: HRDATA = {23'b0, !w_rx_empty, (w_rx_empty ? 8'h00 : w_rx_dout)};
        UART_REG_STATUS: HRDATA = {25'b0, w_status};
        UART_REG_CTRL:   HRDATA = {15'b0, w_loopback, r_baud_div};
        default:         HRDATA = '0;
      endcase
    end
  end

  mfp_uart_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk(HCLK), .i_rst(HRESET), .i_push(w_tx_push), .i_din(HWDATA[7:0]),
    .i_pop(w_tx_pop), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  mfp_uart_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk(HCLK), .i_rst(HRESET), .i_push(w_rx_push), .i_din(r_rx_shift),
    .i_pop(w_rx_pop), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) r_tx_state <= UART_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      UART_IDLE:  if (!w_tx_empty) w_tx_next = UART_START;
      UART_START: if (r_tx_cnt == '0) w_tx_next = UART_DATA;
      UART_DATA:  if (r_tx_cnt == '0 && r_tx_bit == 3'd7) w_tx_next = UART_STOP;
      UART_STOP:  if (r_tx_cnt == '0) w_tx_next = w_tx_empty ? UART_IDLE : UART_START;
      default:    w_tx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop  = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_state)
      UART_IDLE:  w_tx_pop  = !w_tx_empty;
      UART_START: w_tx_line = 1'b0;
      UART_DATA:  w_tx_line = r_tx_shift[0];
      UART_STOP:  w_tx_pop  = (r_tx_cnt == '0) && !w_tx_empty;
      default:    w_tx_line = 1'b1;
    endcase
  end

  assign UART_TX = w_loopback ? 1'b1 : w_tx_line;

  // Counter reloads from r_baud_div at every boundary, so divider writes apply per bit.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
    end else if (w_tx_pop) begin
      r_tx_shift <= w_tx_dout;
      r_tx_cnt   <= r_baud_div;
    end else if (r_tx_state != UART_IDLE) begin
      if (r_tx_cnt == '0) begin
        r_tx_cnt <= r_baud_div;
        if (r_tx_state == UART_START) r_tx_bit <= '0;
        if (r_tx_state == UART_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end
    end
  end

  assign w_rx_in   = w_loopback ? w_tx_line : UART_RX;
  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_rx_half = {1'b0, r_baud_div[15:1]} + {15'b0, r_baud_div[0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= w_rx_in;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) r_rx_state <= UART_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      UART_IDLE:  if (w_rx_fall) w_rx_next = UART_START;
      UART_START: if (r_rx_cnt == '0) w_rx_next = r_rx_s2 ? UART_IDLE : UART_DATA;
      UART_DATA:  if (r_rx_cnt == '0 && r_rx_bit == 3'd7) w_rx_next = UART_STOP;
      UART_STOP:  if (r_rx_cnt == '0) w_rx_next = UART_IDLE;
      default:    w_rx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    w_rx_push = 1'b0;
    w_rx_ferr = 1'b0;
    if (r_rx_state == UART_STOP && r_rx_cnt == '0) begin
      w_rx_push = r_rx_s2;
      w_rx_ferr = !r_rx_s2;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
    end else if (r_rx_state == UART_IDLE) begin
      if (w_rx_fall) r_rx_cnt <= w_rx_half - 16'd1;
    end else if (r_rx_cnt == '0) begin
      r_rx_cnt <= r_baud_div;
      if (r_rx_state == UART_START) r_rx_bit <= '0;
      if (r_rx_state == UART_DATA) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end else begin
      r_rx_cnt <= r_rx_cnt - 16'd1;
    end
  end

endmodule
